// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//
// Contents:
//   arb_state_e      - arbiter FSM states (idle, memory access, completion pulse)
//   *Default         - default width/size constants used by the top-level parameters
//   ptr_inc()        - round-robin pointer increment, wrapping modulo the core count
//
// Optional feature macro used by the files importing this package:
//   MEM_ARB_FIXED_PRIORITY_EN - lowest-index core always wins; no rotating pointer.

package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } arb_state_e;

  localparam int unsigned NumCoresDefault     = 4;
  localparam int unsigned AddrWidthDefault    = 8;
  localparam int unsigned DataWidthDefault    = 16;
  localparam int unsigned AccessCyclesDefault = 2;

  // Next round-robin start position: one past the last winner, wrapping to 0.
  function automatic int unsigned ptr_inc(int unsigned ptr, int unsigned num_cores);
    return ((ptr + 1) >= num_cores) ? 0 : (ptr + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// rr_picker: combinational winner selection for the memory port arbiter.
//
// Ports:
//   req_i   [NUM_CORES]       - per-core request vector
//   ptr_i   [clog2(NUM_CORES)] - round-robin start index (must be < NUM_CORES)
//   idx_o   [clog2(NUM_CORES)] - index of the winning core (0 when none)
//   valid_o                    - at least one request is present
//
// Default build: the winner is the first requesting index at or after ptr_i,
// wrapping modulo NUM_CORES.
// MEM_ARB_FIXED_PRIORITY_EN defined: the winner is the lowest requesting index
// and ptr_i is ignored.

module rr_picker #(
  parameter int unsigned NUM_CORES = 4
) (
  input  logic [NUM_CORES-1:0]         req_i,
  input  logic [$clog2(NUM_CORES)-1:0] ptr_i,
  output logic [$clog2(NUM_CORES)-1:0] idx_o,
  output logic                         valid_o
);

  localparam int unsigned IdxW = $clog2(NUM_CORES);

  int unsigned            cand;
  logic        [IdxW-1:0] cand_idx;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`endif

  // Scan NUM_CORES positions starting at the pointer; the first hit wins.
  always_comb begin
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      cand = k;
`else
      cand = 32'(ptr_i) + k;
      if (cand >= NUM_CORES) begin
        cand = cand - NUM_CORES;
      end
`endif
      cand_idx = cand[IdxW-1:0];
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port among the cores' load/store units.
//
// One core is granted at a time. The granted request (index, we, addr, wdata) is
// latched in idle and replayed to memory for ACCESS_CYCLES cycles; afterwards a
// one-cycle coreDone pulse returns the captured load data. Each access occupies
// the port for ACCESS_CYCLES+2 cycles (grant, access, done).
//
// Ports:
//   clk, reset      - clock; synchronous active-high reset
//   coreReq/coreWe  - per-core request level and access type (1 = store)
//   coreAddr        - flat address bus, core i at slice i
//   coreWData       - flat write-data bus, core i at slice i
//   coreDone        - one-hot one-cycle completion pulse
//   coreRData       - broadcast load data, valid with coreDone
//   busy            - access or completion in progress
//   grantId         - index of the current/last granted core
//   memAddr/memWriteData/memWrite/memRead - memory request, active only in access
//   memReadData     - memory read data, captured on the last access cycle
//
// Build option: MEM_ARB_FIXED_PRIORITY_EN selects fixed lowest-index priority and
// removes the round-robin pointer register.

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_CORES     = NumCoresDefault,
  parameter int unsigned ADDR_WIDTH    = AddrWidthDefault,
  parameter int unsigned DATA_WIDTH    = DataWidthDefault,
  parameter int unsigned ACCESS_CYCLES = AccessCyclesDefault
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CORES-1:0]             coreReq,
  input  logic [NUM_CORES-1:0]             coreWe,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  coreAddr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  coreWData,
  output logic [NUM_CORES-1:0]             coreDone,
  output logic [DATA_WIDTH-1:0]            coreRData,
  output logic                             busy,
  output logic [$clog2(NUM_CORES)-1:0]     grantId,
  output logic [ADDR_WIDTH-1:0]            memAddr,
  output logic [DATA_WIDTH-1:0]            memWriteData,
  output logic                             memWrite,
  output logic                             memRead,
  input  logic [DATA_WIDTH-1:0]            memReadData
);

  localparam int unsigned IdxW = $clog2(NUM_CORES);
  localparam int unsigned CntW = $clog2(ACCESS_CYCLES) + 1;

  arb_state_e state_q, state_d;

  logic [IdxW-1:0]       grant_q, grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]       cyc_cnt_q, cyc_cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [IdxW-1:0]       rr_ptr;
  logic [IdxW-1:0]       win_idx;
  logic                  win_valid;

  logic [ADDR_WIDTH-1:0] core_addr  [NUM_CORES];
  logic [DATA_WIDTH-1:0] core_wdata [NUM_CORES];

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
    assign core_addr[i]  = coreAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign core_wdata[i] = coreWData[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_picker #(
    .NUM_CORES (NUM_CORES)
  ) u_picker (
    .req_i   (coreReq),
    .ptr_i   (rr_ptr),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  // Round-robin pointer: advances past the winner when its access completes.
`ifdef MEM_ARB_FIXED_PRIORITY_EN
  assign rr_ptr = '0;
`else
  logic [IdxW-1:0] rr_ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else if (state_q == StDone) begin
      rr_ptr_q <= IdxW'(ptr_inc(32'(grant_q), NUM_CORES));
    end
  end

  assign rr_ptr = rr_ptr_q;
`endif

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cyc_cnt_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cyc_cnt_q <= cyc_cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state logic. Requester inputs are only sampled in idle, so changes
  // during an access cannot disturb the latched request.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cyc_cnt_d = cyc_cnt_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          grant_d   = win_idx;
          we_d      = coreWe[win_idx];
          addr_d    = core_addr[win_idx];
          wdata_d   = core_wdata[win_idx];
          cyc_cnt_d = CntW'(ACCESS_CYCLES - 1);
          state_d   = StAccess;
        end
      end
      StAccess: begin
        if (cyc_cnt_q == '0) begin
          // Stores leave the last load data in place.
          if (!we_q) begin
            rdata_d = memReadData;
          end
          state_d = StDone;
        end else begin
          cyc_cnt_d = cyc_cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the state only, so all of them are glitch-free
  // registered-state functions and zero outside their active state.
  always_comb begin
    busy         = 1'b0;
    memAddr      = '0;
    memWriteData = '0;
    memWrite     = 1'b0;
    memRead      = 1'b0;
    coreDone     = '0;
    coreRData    = '0;

    unique case (state_q)
      StAccess: begin
        busy         = 1'b1;
        memAddr      = addr_q;
        memWriteData = wdata_q;
        memWrite     = we_q;
        memRead      = !we_q;
      end
      StDone: begin
        busy              = 1'b1;
        coreDone[grant_q] = 1'b1;
        coreRData         = rdata_q;
      end
      default: begin
      end
    endcase
  end

  assign grantId = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (4 cores, 8-bit addresses, 16-bit data, 2 access cycles).
// A transaction-level model tracks which phase of an access the port is in and
// predicts every output each cycle; directed scenarios add literal expectations.

module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int AC = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      coreReq;
  logic [N-1:0]      coreWe;
  logic [N*AW-1:0]   coreAddr;
  logic [N*DW-1:0]   coreWData;
  logic [N-1:0]      coreDone;
  logic [DW-1:0]     coreRData;
  logic              busy;
  logic [1:0]        grantId;
  logic [AW-1:0]     memAddr;
  logic [DW-1:0]     memWriteData;
  logic              memWrite;
  logic              memRead;
  logic [DW-1:0]     memReadData;

  logic [DW-1:0]     mem_arr [256];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int done_core [$];
  int done_cyc  [$];

  // Model state: m_t = 0 idle, 1..AC access cycle number, AC+1 completion.
  int            m_t     = 0;
  int            m_rr    = 0;
  int            m_grant = 0;
  logic          m_we    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;

  always #5 clk = ~clk;

  assign memReadData = mem_arr[memAddr];

  mem_port_arbiter #(
    .NUM_CORES     (N),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .ACCESS_CYCLES (AC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .coreReq      (coreReq),
    .coreWe       (coreWe),
    .coreAddr     (coreAddr),
    .coreWData    (coreWData),
    .coreDone     (coreDone),
    .coreRData    (coreRData),
    .busy         (busy),
    .grantId      (grantId),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .memWrite     (memWrite),
    .memRead      (memRead),
    .memReadData  (memReadData)
  );

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] r, int ptr);
    for (int k = 0; k < N; k++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      if (r[k]) return k;
`else
      if (r[(ptr + k) % N]) return (ptr + k) % N;
`endif
    end
    return -1;
  endfunction

  // Model update on each rising edge from the inputs held stable since the falling edge.
  always @(posedge clk) begin : model
    int w;
    cyc <= cyc + 1;
    if (reset) begin
      m_t     <= 0;
      m_rr    <= 0;
      m_grant <= 0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_rdata <= '0;
    end else if (m_t == 0) begin
      w = pick(coreReq, m_rr);
      if (w >= 0) begin
        m_grant <= w;
        m_we    <= coreWe[w];
        m_addr  <= coreAddr[w*AW +: AW];
        m_wdata <= coreWData[w*DW +: DW];
        m_t     <= 1;
      end
    end else if (m_t <= AC) begin
      if (m_t == AC && !m_we) m_rdata <= mem_arr[m_addr];
      m_t <= m_t + 1;
    end else begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      m_rr <= 0;
`else
      m_rr <= (m_grant + 1) % N;
`endif
      m_t <= 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    logic acc;
    logic dn;
    if (cyc > 0) begin
      acc = (m_t >= 1) && (m_t <= AC);
      dn  = (m_t == AC + 1);
      cmp("busy", 32'(busy), 32'(m_t != 0));
      cmp("grantId", 32'(grantId), 32'(m_grant));
      cmp("memRead", 32'(memRead), 32'(acc && !m_we));
      cmp("memWrite", 32'(memWrite), 32'(acc && m_we));
      cmp("memAddr", 32'(memAddr), 32'(acc ? m_addr : 8'h00));
      cmp("memWriteData", 32'(memWriteData), 32'(acc ? m_wdata : 16'h0000));
      cmp("coreDone", 32'(coreDone), dn ? (32'd1 << m_grant) : 32'd0);
      if (dn) cmp("coreRData", 32'(coreRData), 32'(m_rdata));
      for (int i = 0; i < N; i++) begin
        if (coreDone[i] === 1'b1) begin
          done_core.push_back(i);
          done_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic wait_cycles(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_req(int c, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    coreWe[c]              = w;
    coreAddr[c*AW +: AW]   = a;
    coreWData[c*DW +: DW]  = d;
    coreReq[c]             = 1'b1;
  endtask

  task automatic wait_dones(int target, int budget, string name);
    int k = 0;
    while (done_core.size() < target && k < budget) begin
      wait_cycles(1);
      k++;
    end
    checks++;
    if (done_core.size() < target) begin
      errors++;
      $display("FAIL %s timeout: got %0d completions, expected %0d", name, done_core.size(),
               target);
    end
  endtask

  function automatic int done_at(int i);
    return (i < done_core.size()) ? done_core[i] : 99;
  endfunction

  function automatic int gap_at(int i);
    return (i + 1 < done_cyc.size()) ? (done_cyc[i+1] - done_cyc[i]) : -1;
  endfunction

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n0;
    int exp_order [5];
    int exp_pair  [4];

    reset     = 1'b1;
    coreReq   = '0;
    coreWe    = '0;
    coreAddr  = '0;
    coreWData = '0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 16'(i * 257) ^ 16'h5A5A;
    mem_arr[8'h3C] = 16'hBEEF;

    // Reset state
    wait_cycles(2);
    cmp("rst_busy", 32'(busy), 0);
    cmp("rst_grant", 32'(grantId), 0);
    cmp("rst_done", 32'(coreDone), 0);
    cmp("rst_strobes", 32'({memRead, memWrite}), 0);
    cmp("rst_addr", 32'(memAddr), 0);

    // Single load from core 2
    reset = 1'b0;
    set_req(2, 1'b0, 8'h3C, 16'h0000);
    wait_cycles(1);
    cmp("ld_c1_read", 32'(memRead), 1);
    cmp("ld_c1_addr", 32'(memAddr), 32'h3C);
    cmp("ld_c1_grant", 32'(grantId), 2);
    wait_cycles(1);
    cmp("ld_c2_read", 32'(memRead), 1);
    wait_cycles(1);
    cmp("ld_done", 32'(coreDone), 32'b0100);
    cmp("ld_rdata", 32'(coreRData), 32'hBEEF);
    cmp("ld_read_off", 32'(memRead), 0);
    coreReq[2] = 1'b0;
    wait_cycles(1);
    cmp("ld_idle", 32'(busy), 0);

    // Single store from core 0
    set_req(0, 1'b1, 8'h05, 16'h1234);
    wait_cycles(1);
    cmp("st_c1_write", 32'(memWrite), 1);
    cmp("st_c1_read", 32'(memRead), 0);
    cmp("st_c1_addr", 32'(memAddr), 32'h05);
    cmp("st_c1_wdata", 32'(memWriteData), 32'h1234);
    wait_cycles(1);
    cmp("st_c2_write", 32'(memWrite), 1);
    wait_cycles(1);
    cmp("st_write_off", 32'(memWrite), 0);
    cmp("st_done", 32'(coreDone), 32'b0001);
    coreReq[0] = 1'b0;
    wait_cycles(1);

    // Mid-access changes on core 1 are ignored
    set_req(1, 1'b0, 8'h22, 16'h0000);
    wait_cycles(1);
    cmp("mid_addr1", 32'(memAddr), 32'h22);
    coreAddr[1*AW +: AW] = 8'h99;
    coreReq[1] = 1'b0;
    wait_cycles(1);
    cmp("mid_addr2", 32'(memAddr), 32'h22);
    cmp("mid_read", 32'(memRead), 1);
    wait_cycles(1);
    cmp("mid_done", 32'(coreDone), 32'b0010);
    cmp("mid_rdata", 32'(coreRData), 32'h7878);
    wait_cycles(1);

    // Reset in the first access cycle
    set_req(1, 1'b0, 8'h10, 16'h0000);
    wait_cycles(1);
    cmp("rm_read_on", 32'(memRead), 1);
    reset = 1'b1;
    n0 = done_core.size();
    wait_cycles(1);
    cmp("rm_read_off", 32'(memRead), 0);
    cmp("rm_busy", 32'(busy), 0);
    cmp("rm_grant", 32'(grantId), 0);
    reset   = 1'b0;
    coreReq = '0;
    set_req(1, 1'b0, 8'h11, 16'h0000);
    set_req(3, 1'b0, 8'h33, 16'h0000);
    wait_cycles(1);
    cmp("rm_regrant", 32'(grantId), 1);
    cmp("rm_readdr", 32'(memAddr), 32'h11);
    wait_cycles(2);
    cmp("rm_done", 32'(coreDone), 32'b0010);
    cmp("rm_done_count", 32'(done_core.size()), 32'(n0 + 1));
    coreReq = '0;
    wait_cycles(2);

    // All four cores request continuously from reset
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'(i % 2), 8'(8'h40 + i), 16'(16'h1000 + i));
    wait_cycles(2);
    n0    = done_core.size();
    reset = 1'b0;
    wait_dones(n0 + 5, 60, "contention");
    coreReq = '0;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 5; i++) cmp($sformatf("cont_order%0d", i), 32'(done_at(n0 + i)),
                                    32'(exp_order[i]));
    for (int i = 0; i < 4; i++) cmp($sformatf("cont_gap%0d", i), 32'(gap_at(n0 + i)),
                                    32'(AC + 2));
    wait_cycles(3);

    // Cores 1 and 3 request continuously; core 1 drops after three completions
    reset   = 1'b1;
    coreReq = '0;
    set_req(1, 1'b0, 8'h21, 16'h0000);
    set_req(3, 1'b1, 8'h23, 16'hABCD);
    wait_cycles(2);
    n0    = done_core.size();
    reset = 1'b0;
    wait_dones(n0 + 3, 40, "pair_first");
    coreReq[1] = 1'b0;
    wait_dones(n0 + 4, 20, "pair_last");
    coreReq = '0;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    exp_pair = '{1, 1, 1, 3};
`else
    exp_pair = '{1, 3, 1, 3};
`endif
    for (int i = 0; i < 4; i++) cmp($sformatf("pair_order%0d", i), 32'(done_at(n0 + i)),
                                    32'(exp_pair[i]));
    wait_cycles(3);
    cmp("end_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data-memory port among the processor cores' load/store units. Each core raises a request with address, write-enable and write data; the arbiter grants one core at a time in round-robin order. It drives the memory read/write strobes for a fixed access duration and returns a one-cycle completion pulse with read data. It sits between the per-core store/load sequencers and the shared data memory.

## Interface
- NUM_CORES, 4, number of requesting cores (2–8)
- ADDR_WIDTH, 8, memory address width
- DATA_WIDTH, 16, memory data width
- ACCESS_CYCLES, 2, cycles memRead/memWrite are held per access (≥1)
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- coreReq  input  NUM_CORES  per-core request, level, held until coreDone
- coreWe  input  NUM_CORES  per-core access type (1 = store, 0 = load)
- coreAddr  input  NUM_CORES*ADDR_WIDTH  flat address bus, core i at slice i
- coreWData  input  NUM_CORES*DATA_WIDTH  flat write-data bus, core i at slice i
- coreDone  output  NUM_CORES  one-hot, one-cycle completion pulse
- coreRData  output  DATA_WIDTH  load data, broadcast, valid while coreDone is high
- busy  output  1  high in ACCESS and DONE
- grantId  output  clog2(NUM_CORES)  index of the current/last granted core
- memAddr  output  ADDR_WIDTH  memory address
- memWriteData  output  DATA_WIDTH  memory write data
- memWrite  output  1  memory write strobe
- memRead  output  1  memory read strobe
- memReadData  input  DATA_WIDTH  memory read data

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: when any coreReq bit is set, pick the winner, which is the first requesting index at or after rrPtr (wrapping modulo NUM_CORES).
  - Latch the winner's index, we, addr and wdata into internal registers.
  - Load cycCnt = ACCESS_CYCLES-1 and go to ACCESS.
  - With no requests, stay in IDLE.
- ACCESS:
  - Drive memAddr/memWriteData from the latched registers.
  - memWrite = latched we; memRead = !latched we.
  - Decrement cycCnt each cycle. When cycCnt==0, capture memReadData into the rdata register (loads only) and go to DONE.
- DONE:
  - coreDone[grantId]=1 and coreRData=captured data.
  - Set rrPtr = grantId+1, wrapping to 0 past NUM_CORES-1.
  - Go to IDLE.
- The latched request is immutable during ACCESS. Requester changes or coreReq deassertion mid-access are ignored, and the access completes.
- A core must drop coreReq the cycle after coreDone. If it does not, it is treated as a new request. It wins again only if no other core requests, because rrPtr has moved past it.
- Strobes and coreDone are zero outside their states. memAddr/memWriteData are zero outside ACCESS.
- cycCnt width is clog2(ACCESS_CYCLES)+1 bits. It never wraps below 0.

## Timing
- Reset values: state=IDLE, rrPtr=0, grantId=0, cycCnt=0, rdata reg=0, every output 0.
- Request seen in IDLE at cycle 0 → strobes high cycles 1..ACCESS_CYCLES → coreDone at cycle ACCESS_CYCLES+1.
- The earliest next grant is decided at cycle ACCESS_CYCLES+2. Per-access occupancy is ACCESS_CYCLES+2 cycles.
- Simultaneous requests are resolved in the same IDLE cycle by the round-robin rule. Exactly one grant is made per IDLE cycle.
- Reset asserted in any state returns to IDLE at the next edge. The in-flight access is aborted, no coreDone is issued, and strobes drop the cycle after reset is sampled.

## Configuration
- MEM_ARB_FIXED_PRIORITY_EN defined: the winner is the lowest-index requesting core. rrPtr is removed and held at 0, and grantId still reports the winner.
- Undefined (default): round-robin as described above.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - the default width constants;
  - a function for the modulo-NUM_CORES pointer increment.
- One sub-module, rr_picker: a combinational request vector plus pointer in, winner index plus valid out. It implements both the round-robin and the fixed-priority selection under the macro.
- The top level holds the FSM, the latch registers and cycCnt.

## Test plan
- Single load: core 2 requests addr 0x3C with memReadData=0xBEEF and ACCESS_CYCLES=2 → memRead high for 2 cycles, then coreDone=4'b0100 and coreRData=0xBEEF at cycle 3.
- Single store: core 0 writes 0x1234 to 0x05 → memWrite high for exactly 2 cycles with memAddr=0x05 and memWriteData=0x1234; memRead stays 0.
- Contention: all four cores request continuously from reset → grant order 0,1,2,3,0. One coreDone every 4 cycles.
- Fixed-priority build: cores 1 and 3 request continuously → core 1 is granted every time, and core 3 only after core 1 drops its request.
- Mid-access changes: core 1's coreAddr changes and coreReq drops during ACCESS → memAddr keeps the latched value and coreDone[1] still pulses.
- Reset mid-access: reset in the first ACCESS cycle → strobes are 0 the next cycle, no coreDone is issued, and the next grant starts from core 0.
